memory_stage: RTL

- MEM stage of the pipelined RV64 core, between the EX/MEM and MEM/WB boundaries.
- Takes one excute_output_sign per handshake and issues at most one data-bus transaction for it.
- Aligns store data and builds the byte strobe; extracts and extends load data.
- Holds the result in an internal MEM/WB register, presented as a memory_output_sign.
- Stalls upstream while a bus transaction is outstanding.

---
 rtl/memory_stage_pkg.sv | 70 +++++++
 rtl/memory_stage_mem_align.sv | 42 ++++
 rtl/memory_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the RV64 MEM stage: pipeline boundary structs, access sizes, FSM states.
// MISALIGN_TRAP_EN appends exception fields to memory_output_sign.
package memory_stage_pkg;

    localparam int MS_XLEN      = 64;
    localparam int MS_BUS_BYTES = 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [MS_XLEN-1:0] MCAUSE_LOAD_MISALIGN  = 64'd4;
    localparam logic [MS_XLEN-1:0] MCAUSE_STORE_MISALIGN = 64'd6;

    typedef struct packed {
        logic [MS_XLEN-1:0] pc;
        logic [4:0]         rd;
        logic               RegWrite;
        logic               MemRead;
        logic               MemWrite;
        logic               unsignedLoad;
        msize_t             size;
        logic [MS_XLEN-1:0] result;
        logic [MS_XLEN-1:0] b_reg;
    } excute_output_sign;

`ifdef MISALIGN_TRAP_EN
    typedef struct packed {
        logic               valid;
        logic [MS_XLEN-1:0] mcause;
        logic [MS_XLEN-1:0] mtval;
    } mem_exc_t;
`endif

    typedef struct packed {
        logic [MS_XLEN-1:0]      pc;
        logic [4:0]              rd;
        logic                    RegWrite;
        logic [MS_XLEN-1:0]      result;
        logic [MS_XLEN-1:0]      dbusdata;
        logic [MS_XLEN-1:0]      addr;
        logic [MS_BUS_BYTES-1:0] strobe;
        logic                    valid;
`ifdef MISALIGN_TRAP_EN
        mem_exc_t                exc;
`endif
    } memory_output_sign;

    // An access is aligned when the low address bits below its size are zero.
    function automatic logic is_misaligned(input logic [2:0] off, input msize_t size);
        logic r;
        case (size)
            MSIZE1:  r = 1'b0;
            MSIZE2:  r = off[0];
            MSIZE4:  r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Lane alignment for a 64-bit data bus: store strobe/data shift, load extract/extend, misalign flag.
// Purely combinational (0 cycles); no flow control of its own.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]              i_addr_off,
    input  msize_t                  i_size,
    input  logic                    i_unsigned,
    input  logic [MS_XLEN-1:0]      i_store_dat,
    input  logic [MS_XLEN-1:0]      i_bus_rdata,
    output logic [MS_BUS_BYTES-1:0] o_strobe,
    output logic [MS_XLEN-1:0]      o_wdata,
    output logic [MS_XLEN-1:0]      o_load_dat,
    output logic                    o_misalign
);

    logic [3:0]              w_bytes;
    logic [MS_BUS_BYTES-1:0] w_mask;
    logic [5:0]              w_shift;
    logic [MS_XLEN-1:0]      w_raw;

    assign w_bytes = 4'd1 << i_size[1:0];
    // For 8 bytes the shift wraps to 0 and the subtraction yields all ones.
    assign w_mask  = (8'd1 << w_bytes) - 8'd1;
    assign w_shift = {i_addr_off, 3'b000};

    assign o_strobe   = w_mask << i_addr_off;
    assign o_wdata    = i_store_dat << w_shift;
    assign w_raw      = i_bus_rdata >> w_shift;
    assign o_misalign = is_misaligned(i_addr_off, i_size);

    always_comb begin
        o_load_dat = w_raw;
        case (i_size)
            MSIZE1:  o_load_dat = {{56{w_raw[7]  & ~i_unsigned}}, w_raw[7:0]};
            MSIZE2:  o_load_dat = {{48{w_raw[15] & ~i_unsigned}}, w_raw[15:0]};
            MSIZE4:  o_load_dat = {{32{w_raw[31] & ~i_unsigned}}, w_raw[31:0]};
            default: o_load_dat = w_raw;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: one data-bus transaction per entry, result in MEM/WB reg; out_valid 1 cycle after accept (non-mem) or after data_ok.
// Upstream held off (in_ready=0, stall_req) while a transaction is outstanding or WB stalls; MISALIGN_TRAP_EN enables misalign traps.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BUS_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  excute_output_sign     in_sign,
    input  logic                  flush,
    output logic                  dbus_valid,
    output logic [XLEN-1:0]       dbus_addr,
    output logic [2:0]            dbus_size,
    output logic [BUS_BYTES-1:0]  dbus_strobe,
    output logic [XLEN-1:0]       dbus_wdata,
    input  logic                  dbus_addr_ok,
    input  logic                  dbus_data_ok,
    input  logic [XLEN-1:0]       dbus_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output memory_output_sign     out_sign,
    output logic                  stall_req
);

    mem_state_t        r_state, w_state_nxt;
    logic              r_kill, w_kill_nxt;
    excute_output_sign r_entry;
    memory_output_sign r_out, w_out_d, w_direct, w_bus_out;
    logic              w_out_we;
    logic              w_accept;
    logic              w_in_mem;
    logic              w_in_trap;
    logic              w_in_req;
    logic [BUS_BYTES-1:0] w_strobe;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_load_dat;
    logic              w_entry_misalign;
    logic              w_unused_bus_flags;

    // Only data_ok ends a transaction; the address handshake carries no state here.
    assign w_unused_bus_flags = dbus_addr_ok ^ w_entry_misalign;

    mem_align u_align (
        .i_addr_off  (r_entry.result[2:0]),
        .i_size      (r_entry.size),
        .i_unsigned  (r_entry.unsignedLoad),
        .i_store_dat (r_entry.b_reg),
        .i_bus_rdata (dbus_rdata),
        .o_strobe    (w_strobe),
        .o_wdata     (w_wdata),
        .o_load_dat  (w_load_dat),
        .o_misalign  (w_entry_misalign)
    );

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_in_mem  = in_sign.MemRead | in_sign.MemWrite;
`ifdef MISALIGN_TRAP_EN
    assign w_in_trap = w_in_mem & is_misaligned(in_sign.result[2:0], in_sign.size);
`else
    assign w_in_trap = 1'b0;
`endif
    assign w_in_req  = w_in_mem & ~w_in_trap;

    assign dbus_valid  = (r_state == REQ);
    assign stall_req   = (r_state == REQ);
    assign dbus_addr   = dbus_valid ? r_entry.result : '0;
    assign dbus_size   = dbus_valid ? r_entry.size : 3'd0;
    assign dbus_strobe = (dbus_valid & r_entry.MemWrite) ? w_strobe : '0;
    assign dbus_wdata  = (dbus_valid & r_entry.MemWrite) ? w_wdata : '0;

    assign out_valid = (r_state == DONE);
    assign out_sign  = r_out;

    // Result for an entry that completes without touching the bus.
    always_comb begin
        w_direct          = '0;
        w_direct.pc       = in_sign.pc;
        w_direct.rd       = in_sign.rd;
        w_direct.RegWrite = in_sign.RegWrite;
        w_direct.result   = in_sign.result;
`ifdef MISALIGN_TRAP_EN
        if (w_in_trap) begin
            w_direct.RegWrite   = 1'b0;
            w_direct.exc.valid  = 1'b1;
            w_direct.exc.mcause = in_sign.MemWrite ? MCAUSE_STORE_MISALIGN : MCAUSE_LOAD_MISALIGN;
            w_direct.exc.mtval  = in_sign.result;
        end
`endif
    end

    always_comb begin
        w_bus_out          = '0;
        w_bus_out.pc       = r_entry.pc;
        w_bus_out.rd       = r_entry.rd;
        w_bus_out.RegWrite = r_entry.RegWrite;
        w_bus_out.result   = r_entry.result;
        w_bus_out.dbusdata = r_entry.MemRead ? w_load_dat : '0;
        w_bus_out.addr     = r_entry.result;
        w_bus_out.strobe   = r_entry.MemWrite ? w_strobe : '0;
        w_bus_out.valid    = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kill_nxt  = r_kill;
        w_out_we    = 1'b0;
        w_out_d     = r_out;
        case (r_state)
            REQ: begin
                if (flush) w_kill_nxt = 1'b1;
                if (dbus_data_ok) begin
                    w_kill_nxt = 1'b0;
                    if (r_kill | flush) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DONE;
                        w_out_we    = 1'b1;
                        w_out_d     = w_bus_out;
                    end
                end
            end
            DONE: begin
                if (flush | out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = r_state;
        endcase
        // Acceptance only happens from IDLE or a draining DONE, so it overrides the above.
        if (w_accept) begin
            if (w_in_req) begin
                w_state_nxt = REQ;
            end else begin
                w_state_nxt = DONE;
                w_out_we    = 1'b1;
                w_out_d     = w_direct;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
            r_entry <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kill  <= w_kill_nxt;
            if (w_accept) r_entry <= in_sign;
            if (w_out_we) r_out <= w_out_d;
        end
    end

endmodule
